// File: rtl/divisor_pkg.sv
// Shared encodings for the button-driven divider console: FSM states,
// phase codes shown to the user, and button indices.
package divisor_pkg;

  localparam logic [2:0] S_NUM  = 3'd0;
  localparam logic [2:0] S_DEN  = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_QUO  = 3'd3;
  localparam logic [2:0] S_REM  = 3'd4;

  localparam logic [1:0] PH_NUM = 2'd0;
  localparam logic [1:0] PH_DEN = 2'd1;
  localparam logic [1:0] PH_QUO = 2'd2;
  localparam logic [1:0] PH_REM = 2'd3;

  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_OK   = 2;
  localparam int N_BTN    = 3;

  // The calculation phase still shows the denominator, so it reports as DEN.
  function automatic logic [1:0] phase_of(input logic [2:0] st);
    logic [1:0] ph;
    ph = PH_NUM;
    case (st)
      S_NUM:  ph = PH_NUM;
      S_DEN:  ph = PH_DEN;
      S_CALC: ph = PH_DEN;
      S_QUO:  ph = PH_QUO;
      S_REM:  ph = PH_REM;
      default: ph = PH_NUM;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/divisor_nb_div_restoring.sv
// Restoring sequential divider: one quotient bit per clock, MSB first.
// q/r/done are the outcome of the step taken at the coming edge; the owner registers them.
module div_restoring
  import divisor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   prem_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH:0]   prem_d;
  logic [WIDTH-1:0] acc_d;

  // acc_q starts as the dividend and fills with quotient bits from the right.
  always_comb begin
    shifted = {prem_q, acc_q[WIDTH-1]};
    trial   = shifted - {2'b00, b_q};
    ge      = ~trial[WIDTH+1];
    prem_d  = ge ? trial[WIDTH:0] : shifted[WIDTH:0];
    acc_d   = {acc_q[WIDTH-2:0], ge};
  end

  assign q    = acc_d;
  assign r    = prem_d[WIDTH-1:0];
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      prem_q <= '0;
      acc_q  <= '0;
      b_q    <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH);
      prem_q <= '0;
      acc_q  <= a;
      b_q    <= b;
    end else if (busy_q) begin
      prem_q <= prem_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/divisor_nb.sv
// Button-driven divider console: edit numerator and denominator with up/down,
// confirm with ok, then step through quotient and remainder on the LEDs.
module divisor_nb
  import divisor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             ok,
  output logic [WIDTH-1:0] leds,
  output logic [1:0]       phase,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  logic [N_BTN-1:0] btn_pin;
  logic [N_BTN-1:0] press;

  assign btn_pin = {ok, down, up};

  // Active-low pins: a press is the first synchronised low after a high.
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic sync1_q;
      logic sync2_q;
      logic prev_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          prev_q  <= 1'b1;
        end else begin
          sync1_q <= btn_pin[gi];
          sync2_q <= sync1_q;
          prev_q  <= sync2_q;
        end
      end

      assign press[gi] = ~sync2_q & prev_q;
    end
  endgenerate

  logic press_up;
  logic press_down;
  logic press_ok;

  assign press_up   = press[BTN_UP];
  assign press_down = press[BTN_DOWN];
  assign press_ok   = press[BTN_OK];

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             div_start;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             div_busy;
  logic             div_done;

  div_restoring #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (num_q),
    .b     (den_q),
    .q     (div_q),
    .r     (div_r),
    .busy  (div_busy),
    .done  (div_done)
  );

  // Wrapping edit; opposing presses in the same cycle cancel out.
  function automatic logic [WIDTH-1:0] edit_val(input logic [WIDTH-1:0] v,
                                                input logic inc,
                                                input logic dec);
    logic [WIDTH-1:0] res;
    res = v;
    if (inc && !dec) begin
      res = v + WIDTH'(1);
    end else if (dec && !inc) begin
      res = v - WIDTH'(1);
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    den_d     = den_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_NUM: begin
        if (press_ok) begin
          state_d = S_DEN;
        end else begin
          num_d = edit_val(num_q, press_up, press_down);
        end
      end
      S_DEN: begin
        if (press_ok) begin
          if (den_q == '0) begin
            // Zero divisor skips the divider and reports a saturated quotient.
            state_d = S_QUO;
            quo_d   = '1;
            rem_d   = num_q;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d   = S_CALC;
            div_start = 1'b1;
            dz_d      = 1'b0;
          end
        end else begin
          den_d = edit_val(den_q, press_up, press_down);
        end
      end
      S_CALC: begin
        if (div_done) begin
          state_d = S_QUO;
          quo_d   = div_q;
          rem_d   = div_r;
          done_d  = 1'b1;
        end
      end
      S_QUO: begin
        if (press_ok) begin
          state_d = S_REM;
        end
      end
      S_REM: begin
        if (press_ok) begin
          state_d = S_NUM;
        end
      end
      default: state_d = S_NUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_NUM;
      num_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      den_q   <= den_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    leds = num_q;
    case (state_q)
      S_NUM:  leds = num_q;
      S_DEN:  leds = den_q;
      S_CALC: leds = den_q;
      S_QUO:  leds = quo_q;
      S_REM:  leds = rem_q;
      default: leds = num_q;
    endcase
  end

  assign phase    = phase_of(state_q);
  assign busy     = div_busy;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: doc/divisor_nb.md
Name: divisor_nb

Overview:
- Parametrised successor of the 4-bit button-driven divider console.
- User enters numerator and denominator with up/down buttons and confirms each with ok.
- A restoring sequential divider then computes the quotient and remainder; the LEDs step through numerator, denominator, quotient and remainder.
- Adds, beyond the 4-bit console:
  - WIDTH generalisation
  - button synchronisation and press-edge detection
  - explicit busy/done handshake
  - divide-by-zero handling
  - phase output

Parameters:
- WIDTH, 4, operand/result width in bits (2..16).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- up  input  1  increment button, active-low, asynchronous to clk
- down  input  1  decrement button, active-low, asynchronous to clk
- ok  input  1  confirm/advance button, active-low, asynchronous to clk
- leds  output  WIDTH  value for the current phase
- phase  output  2  0=NUM, 1=DEN/CALC, 2=QUO, 3=REM
- busy  output  1  high while division iterates
- done  output  1  one-cycle pulse when quotient/remainder become valid
- div_zero  output  1  last division had denominator 0; held until next division starts or reset

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1, all state clears:
  - FSM to S_NUM
  - num=0, den=0, quo=0, rem=0
  - busy=0, done=0, div_zero=0, phase=0, leds=0
  - synchroniser flops to the released value (1)
- rst mid-calculation aborts the division; no done pulse.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a previous-value flop.
  - Press event = synchronised signal low while previous-value flop is high: one cycle per press, regardless of hold time.
  - A pin first sampled low at edge k takes effect at edge k+2.
  - Release events are ignored.
- FSM states and transitions:
  - S_NUM: up-press increments num, down-press decrements num; ok-press goes to S_DEN.
  - S_DEN: up/down edit den; ok-press with den≠0 goes to S_CALC.
  - S_DEN, ok-press with den=0: go directly to S_QUO with quo=all ones, rem=num, div_zero=1, done pulsed in the cycle S_QUO is entered; no S_CALC.
  - S_CALC: restoring division, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits wide.
  - S_CALC timing: entered at edge e, busy=1 for cycles e..e+WIDTH-1; results registered and FSM moves to S_QUO at edge e+WIDTH; done=1 for that one cycle; busy=0.
  - S_CALC ignores all presses (ok included).
  - S_QUO: ok-press goes to S_REM; up/down ignored.
  - S_REM: ok-press goes to S_NUM; num and den are retained for editing; quo/rem are retained until the next division.
- Entering S_CALC clears div_zero.
- Editing arithmetic:
  - Modulo 2^WIDTH: up at all-ones gives 0; down at 0 gives all-ones.
  - Simultaneous up and down presses in the same cycle: no change.
  - ok together with up/down in the same cycle: ok wins, operand unchanged.
- Outputs:
  - leds = num in S_NUM, den in S_DEN and S_CALC, quo in S_QUO, rem in S_REM.
  - leds/phase are combinational from registered state; no extra latency.
- Invariant when div_zero=0: num = quo*den + rem, with rem < den.

Decomposition:
- Shared package (divisor_pkg) holds:
  - FSM state encoding: S_NUM, S_DEN, S_CALC, S_QUO, S_REM
  - phase codes: PH_NUM=0, PH_DEN=1, PH_QUO=2, PH_REM=3
- One sub-module: div_restoring.
  - Ports: clk, rst, start, a[WIDTH], b[WIDTH] → q, r, busy, done.
  - Contains the iteration counter and partial-remainder logic.
  - Top level holds synchronisers, edge detectors, operand counters, FSM and LED mux.

Test Plan:
- WIDTH=4, reset, 13 up-presses, ok, 4 up-presses, ok → busy high exactly 4 cycles, done pulse once, phase=2, leds=3; ok → phase=3, leds=1; div_zero=0.
- WIDTH=4, num=7, den=0, ok → no busy cycle, phase=2, leds=15, div_zero=1; ok → leds=7; next valid division clears div_zero on entering S_CALC.
- WIDTH=4, from reset press down once in S_NUM → leds=15; up once → leds=0; up+down asserted same cycle → leds unchanged; button held 50 cycles → single increment.
- WIDTH=8, num=255, den=16 → busy 8 cycles, quo=15, rem=15; then num=5, den=9 → quo=0, rem=5.
- During S_CALC press ok and up → ignored, result and timing unchanged; assert rst at cycle 2 of S_CALC → next cycle phase=0, leds=0, busy=0, no done pulse.
- Randomised WIDTH=6 sweep of 200 operand pairs with den≠0 → quo/rem match num/den and num%den; done exactly WIDTH cycles after S_CALC entry.
